seg_scan_arbiter: RTL and testbench
===================================

SEG_SCAN_ARBITER -- requirements
Module: seg_scan_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk_1k and clr_sw_n.
REQ-002 SHALL provide parameter BLINK_PERIOD, default 1000, giving the blink period in clk_1k cycles; it SHALL be even and at least 8.
REQ-003 SHALL provide these ports:
- clk_1k  in  1  1 kHz system clock, rising edge.
- clr_sw_n  in  1  async active-low reset.
- src_req  in  4  display request per source: 0 clock, 1 alarm-set, 2 stopwatch, 3 timer. Bit 0 is ignored; the clock source is always requesting.
- urgent  in  2  bit0 alarm ringing, bit1 timer expired; level signals.
- src_digits  in  128  8 BCD nibbles per source. Source s occupies [32s+31:32s]; nibble i is digit i, with digit 0 leftmost.
- src_blink  in  32  per-source 8-bit blink mask at [8s+7:8s].
- src_dp  in  32  per-source 8-bit decimal-point mask.
- seg_data  out  8  segments, active-high: bit0=a through bit6=g, bit7=dp.
- seg_sel  out  8  digit select, active-low, one-hot-low.
- grant  out  2  source currently displayed.
- frame_start  out  1  one-cycle pulse when digit 0 is driven.

Function
REQ-004 SHALL advance the scan index 0..7 by one per clk_1k cycle and wrap 7->0, giving a 125 Hz frame.
REQ-005 SHALL register seg_sel and seg_data with one cycle of latency from the scan index; when digit i is driven, seg_sel = ~(8'b1<<i).
REQ-006 SHALL decode each nibble as follows:
- 0-9: standard 7-segment patterns (for example, 0 = 7'h3F, 8 = 7'h7F).
- 4'hA: '-' (7'h40).
- 4'hB-4'hF: blank.
seg_data[7] SHALL equal the granted source's src_dp[i].
REQ-007 SHALL evaluate arbitration only in the cycle where the scan index is 7. The new grant SHALL take effect with digit 0 of the next frame, so worst-case switch latency is 8 cycles.
REQ-008 SHALL use this priority, highest first:
1. urgent[1] -> source 3.
2. urgent[0] -> source 1.
3. src_req[2] -> source 2.
4. src_req[3] -> source 3.
5. src_req[1] -> source 1.
6. Otherwise source 0.
REQ-009 SHALL have no fairness: a higher request holds the display indefinitely.
REQ-010 SHALL, when the grant changes value, set a guard flag that blanks the whole next frame. During the guard frame seg_data = 8'h00 while seg_sel keeps scanning. The guard flag SHALL clear at the end of that frame.
REQ-011 SHALL run a free-running blink counter 0..BLINK_PERIOD-1 that wraps to 0 and is independent of the scan index.
REQ-012 SHALL, in normal blink, blank digit i when src_blink[grant][i]=1 and counter >= BLINK_PERIOD/2.
REQ-013 SHALL, while the current grant came from an urgent bit, blank all 8 digits when counter[bit for BLINK_PERIOD/8 granularity] falls in an odd eighth. This gives 4 on/off pairs per period and src_blink is ignored.
REQ-014 SHALL sample src_digits, src_blink and src_dp live each cycle for the granted source; data changes mid-frame appear at the next digit driven.
REQ-015 SHALL, if urgent deasserts mid-frame, keep the grant until the next index-7 evaluation.
REQ-016 SHALL, when urgent and src_req change in the same cycle as index 7, use the values sampled in that cycle.
REQ-017 SHALL assert frame_start in the same cycle seg_sel = 8'hFE.

Reset
REQ-018 SHALL, while clr_sw_n=0, immediately force:
- seg_sel = 8'hFF
- seg_data = 8'h00
- grant = 0
- frame_start = 0
- scan index = 0
- blink counter = 0
- guard = 0
REQ-019 SHALL, after release, drive digit 0 on the first rising edge (seg_sel = 8'hFE, frame_start = 1) with grant 0.
REQ-020 SHALL, on reset asserted mid-frame or mid-guard, abandon the frame with no residual guard or blink phase.

Verification
REQ-021 Reset then idle, clock digits 12345678, src_blink=0 -> seg_sel cycles FE,FD,...,7F every 8 cycles; digit 0 seg_data=8'h06, digit 7 seg_data=8'h7F.
REQ-022 Raise src_req[2] at scan index 3 -> grant stays 0 through index 7, becomes 2 at the next digit 0; that frame is all seg_data=00; the following frame shows stopwatch digits.
REQ-023 Clock src_blink[7:0]=8'h03 with BLINK_PERIOD=1000 -> digits 0-1 show normally for counter 0-499 and read 8'h00 for counter 500-999; digits 2-7 are unaffected.
REQ-024 With src_req[2]=1, assert urgent[1] -> grant switches 2->3 at the frame boundary, one guard frame follows, then all digits flash (counter 0-124 on, 125-249 off); on urgent[1] release, grant returns to 2 with one guard frame.
REQ-025 Pulse clr_sw_n low for 2 cycles during a guard frame at index 5 -> outputs are FF/00 immediately; after release digit 0 is driven with grant 0 and guard 0.

Source files
------------

// File: rtl/seg_scan_arbiter.sv
// Eight-digit multiplexed 7-segment scanner that arbitrates between four display sources,
// blanks one guard frame on every grant change, and applies per-digit or urgent blinking.
module seg_scan_arbiter #(
    parameter int BLINK_PERIOD = 1000
) (
    input  logic         clk_1k,
    input  logic         clr_sw_n,
    input  logic [3:0]   src_req,
    input  logic [1:0]   urgent,
    input  logic [127:0] src_digits,
    input  logic [31:0]  src_blink,
    input  logic [31:0]  src_dp,
    output logic [7:0]   seg_data,
    output logic [7:0]   seg_sel,
    output logic [1:0]   grant,
    output logic         frame_start
);
    localparam int CNT_W = $clog2(BLINK_PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_PERIOD - 1);
    localparam logic [CNT_W-1:0] HALF    = CNT_W'(BLINK_PERIOD / 2);
    localparam logic [CNT_W-1:0] EIGHTH  = CNT_W'(BLINK_PERIOD / 8);
    localparam logic [CNT_W-1:0] QUARTER = CNT_W'(2 * (BLINK_PERIOD / 8));

    logic [2:0]       idx_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       disp_grant_q;
    logic             guard_q, guard_d;
    logic             urg_q, urg_d;
    logic [7:0]       sel_q;
    logic [7:0]       data_q, data_d;
    logic             fs_q;

    logic [3:0]       nib;
    logic             blink_bit;
    logic             dp_bit;
    logic             blank;

    // Source 0 is the implicit fallback, so its request bit carries no information.
    logic unused_req0;
    assign unused_req0 = src_req[0];

    function automatic logic [6:0] decode_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h40;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        grant_d = grant_q;
        guard_d = guard_q;
        urg_d   = urg_q;
        cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;

        if (idx_q == 3'd7) begin
            if (urgent[1])       grant_d = 2'd3;
            else if (urgent[0])  grant_d = 2'd1;
            else if (src_req[2]) grant_d = 2'd2;
            else if (src_req[3]) grant_d = 2'd3;
            else if (src_req[1]) grant_d = 2'd1;
            else                 grant_d = 2'd0;
            guard_d = (grant_d != grant_q);
            urg_d   = |urgent;
        end

        nib       = src_digits[{grant_q, idx_q, 2'b00} +: 4];
        blink_bit = src_blink[{grant_q, idx_q}];
        dp_bit    = src_dp[{grant_q, idx_q}];

        // Urgent flashing overrides the per-digit mask: off during odd eighths of the period.
        if (guard_q)    blank = 1'b1;
        else if (urg_q) blank = ((cnt_q % QUARTER) >= EIGHTH);
        else            blank = blink_bit && (cnt_q >= HALF);

        data_d = blank ? 8'h00 : {dp_bit, decode_seg(nib)};
    end

    always_ff @(posedge clk_1k or negedge clr_sw_n) begin
        if (!clr_sw_n) begin
            idx_q        <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            disp_grant_q <= '0;
            guard_q      <= 1'b0;
            urg_q        <= 1'b0;
            sel_q        <= 8'hFF;
            data_q       <= 8'h00;
            fs_q         <= 1'b0;
        end else begin
            idx_q        <= idx_q + 3'd1;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            disp_grant_q <= grant_q;
            guard_q      <= guard_d;
            urg_q        <= urg_d;
            sel_q        <= ~(8'd1 << idx_q);
            data_q       <= data_d;
            fs_q         <= (idx_q == 3'd0);
        end
    end

    assign seg_sel     = sel_q;
    assign seg_data    = data_q;
    assign grant       = disp_grant_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Bench for seg_scan_arbiter: decode table, directed frame/blink/urgent/reset sequences,
// and randomized traffic against a frame-level reference model.
module tb_seg_scan_arbiter;
    localparam int P = 1000;

    logic         clk_1k   = 1'b0;
    logic         clr_sw_n = 1'b1;
    logic [3:0]   src_req  = '0;
    logic [1:0]   urgent   = '0;
    logic [127:0] src_digits = '0;
    logic [31:0]  src_blink  = '0;
    logic [31:0]  src_dp     = '0;
    logic [7:0]   seg_data;
    logic [7:0]   seg_sel;
    logic [1:0]   grant;
    logic         frame_start;

    seg_scan_arbiter #(.BLINK_PERIOD(P)) dut (
        .clk_1k      (clk_1k),
        .clr_sw_n    (clr_sw_n),
        .src_req     (src_req),
        .urgent      (urgent),
        .src_digits  (src_digits),
        .src_blink   (src_blink),
        .src_dp      (src_dp),
        .seg_data    (seg_data),
        .seg_sel     (seg_sel),
        .grant       (grant),
        .frame_start (frame_start)
    );

    always #5 clk_1k = ~clk_1k;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: m_t counts cycles since reset release; the frame grant, its guard
    // flag and whether it came from an urgent bit are decided once per frame.
    int         m_t     = 0;
    logic [1:0] m_grant = '0;
    logic       m_guard = 1'b0;
    logic       m_urg   = 1'b0;
    logic [6:0] lut [16];

    typedef struct {
        logic [3:0] nib;
        logic       dp;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [16];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at t=%0d: got %h, expected %h", name, m_t - 1, act, exp);
    endtask

    function automatic logic [1:0] prio();
        if (urgent[1])  return 2'd3;
        if (urgent[0])  return 2'd1;
        if (src_req[2]) return 2'd2;
        if (src_req[3]) return 2'd3;
        if (src_req[1]) return 2'd1;
        return 2'd0;
    endfunction

    task automatic step();
        int idx, cnt, g;
        logic [3:0] nib;
        logic [7:0] e_data, e_sel;
        logic [1:0] e_grant, ng;
        logic       e_fs;
        idx = m_t % 8;
        cnt = m_t % P;
        g   = int'(m_grant);
        nib = src_digits[32*g + 4*idx +: 4];
        e_data = {src_dp[8*g + idx], lut[nib]};
        if (m_guard) e_data = 8'h00;
        else if (m_urg) begin
            if ((cnt / (P/8)) % 2 == 1) e_data = 8'h00;
        end else if (src_blink[8*g + idx] && cnt >= P/2) e_data = 8'h00;
        e_sel   = ~(8'h01 << idx);
        e_grant = m_grant;
        e_fs    = (idx == 0);
        if (idx == 7) begin
            ng      = prio();
            m_guard = (ng != m_grant);
            m_urg   = (urgent != 2'b00);
            m_grant = ng;
        end
        m_t++;
        @(posedge clk_1k);
        #1;
        check("seg_sel", seg_sel, e_sel);
        check("seg_data", seg_data, e_data);
        check("grant", {6'b0, grant}, {6'b0, e_grant});
        check("frame_start", {7'b0, frame_start}, {7'b0, e_fs});
    endtask

    task automatic do_reset();
        clr_sw_n = 1'b0;
        #1;
        check("rst_sel_now", seg_sel, 8'hFF);
        check("rst_data_now", seg_data, 8'h00);
        check("rst_grant_now", {6'b0, grant}, 8'h00);
        check("rst_fs_now", {7'b0, frame_start}, 8'h00);
        @(posedge clk_1k);
        @(posedge clk_1k);
        #1;
        check("rst_sel_hold", seg_sel, 8'hFF);
        check("rst_data_hold", seg_data, 8'h00);
        clr_sw_n = 1'b1;
        m_t = 0;
        m_grant = '0;
        m_guard = 1'b0;
        m_urg = 1'b0;
    endtask

    initial begin
        lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        vecs = '{'{4'h0, 1'b0, 8'h3F}, '{4'h1, 1'b1, 8'h86}, '{4'h2, 1'b0, 8'h5B},
                 '{4'h3, 1'b0, 8'h4F}, '{4'h4, 1'b1, 8'hE6}, '{4'h5, 1'b0, 8'h6D},
                 '{4'h6, 1'b0, 8'h7D}, '{4'h7, 1'b0, 8'h07}, '{4'h8, 1'b1, 8'hFF},
                 '{4'h9, 1'b0, 8'h6F}, '{4'hA, 1'b0, 8'h40}, '{4'hB, 1'b0, 8'h00},
                 '{4'hC, 1'b1, 8'h80}, '{4'hD, 1'b0, 8'h00}, '{4'hE, 1'b0, 8'h00},
                 '{4'hF, 1'b0, 8'h00}};
        #2;

        // Idle clock display, digits 1..8, no blink.
        src_digits[31:0] = 32'h8765_4321;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            step();
            if ((m_t - 1) % 8 == 0) check("r021_digit0", seg_data, 8'h06);
            if ((m_t - 1) % 8 == 7) check("r021_digit7", seg_data, 8'h7F);
        end

        // Decode table: all eight clock digits set to one nibble.
        for (int v = 0; v < 16; v++) begin
            src_digits[31:0] = {8{vecs[v].nib}};
            src_dp[7:0]      = {8{vecs[v].dp}};
            step();
            check("decode_tbl", seg_data, vecs[v].exp);
        end
        src_digits[31:0] = 32'h8765_4321;
        src_dp = '0;

        // Stopwatch request raised at scan index 3.
        src_digits[95:64] = 32'h7654_3210;
        while (m_t % 8 != 3) step();
        src_req = 4'b0100;
        while (m_t % 8 != 0) begin
            step();
            check("r022_hold", {6'b0, grant}, 8'h00);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            check("r022_grant", {6'b0, grant}, 8'h02);
            check("r022_guard", seg_data, 8'h00);
        end
        step();
        check("r022_show", seg_data, 8'h3F);
        for (int k = 0; k < 7; k++) step();

        // Digits 0-1 blink on the clock source.
        src_req   = 4'b0000;
        src_blink = 32'h0000_0003;
        do_reset();
        for (int k = 0; k < P; k++) begin
            step();
            case (m_t - 1)
                9:   check("r023_d1_on", seg_data, 8'h5B);
                496: check("r023_d0_on", seg_data, 8'h06);
                504: check("r023_d0_off", seg_data, 8'h00);
                505: check("r023_d1_off", seg_data, 8'h00);
                506: check("r023_d2_steady", seg_data, 8'h4F);
                993: check("r023_d1_late", seg_data, 8'h00);
                default: ;
            endcase
        end
        src_blink = '0;

        // Urgent timer over an active stopwatch, then release.
        src_req = 4'b0100;
        src_digits[127:96] = 32'h9999_9999;
        do_reset();
        for (int k = 0; k < 24; k++) step();
        check("r024_pre", {6'b0, grant}, 8'h02);
        urgent = 2'b10;
        for (int k = 0; k < 16; k++) step();
        check("r024_guard", seg_data, 8'h00);
        step();
        check("r024_grant3", {6'b0, grant}, 8'h03);
        for (int k = 0; k < 300; k++) begin
            step();
            if (m_t - 1 == 128) check("r024_flash_off", seg_data, 8'h00);
            if (m_t - 1 == 256) check("r024_flash_on", seg_data, 8'h6F);
        end
        urgent = 2'b00;
        for (int k = 0; k < 24; k++) step();
        check("r024_back", {6'b0, grant}, 8'h02);

        // Reset pulsed inside a guard frame.
        do_reset();
        while (m_t != 14) step();
        do_reset();
        step();
        check("r025_sel", seg_sel, 8'hFE);
        check("r025_fs", {7'b0, frame_start}, 8'h01);
        check("r025_grant", {6'b0, grant}, 8'h00);
        check("r025_noguard", seg_data, 8'h06);
        for (int k = 0; k < 16; k++) step();

        // Randomized traffic.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 3) == 0)  src_digits = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 15) == 0) src_blink = $urandom & $urandom;
            if ($urandom_range(0, 7) == 0)  src_dp = $urandom;
            if ($urandom_range(0, 19) == 0) src_req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) urgent = 2'($urandom_range(0, 3));
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
